// File: rtl/multicycle_alu.sv
// Multicycle ALU: latches operands on START, then runs 1, WIDTH or n steps
// (single-cycle ops, shift-add multiply, bit-serial shifts) before
// publishing a registered RESULT/ZERO together with a one-cycle DONE pulse.
module multicycle_alu #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic [2:0]       SELECT,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             BUSY,
  output logic             DONE
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_sel;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_done;

  logic             w_accept;
  logic             w_lastStep;
  logic [CW-1:0]    w_steps;
  logic [WIDTH-1:0] w_product;
  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_sra;
  logic             w_shiftEn;
  logic [WIDTH-1:0] w_opResult;

  assign w_accept   = (r_state == IDLE) && START;
  assign w_lastStep = (r_state == EXEC) && (r_count == CW'(1));

  // Shift-add partial product and single-bit shifts of the working operand
  assign w_product = r_acc + (r_b[0] ? r_a : '0);
  assign w_shl     = {r_a[WIDTH-2:0], 1'b0};
  assign w_sra     = {r_a[WIDTH-1], r_a[WIDTH-1:1]};
  assign w_shiftEn = (r_b[SHW-1:0] != '0);

  // State register; reset forces IDLE immediately
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state: leave IDLE on START, return once the last step is done
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (START) w_stateNext = EXEC;
      EXEC:    if (r_count == CW'(1)) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Step count for an op about to be accepted; a zero shift still takes one step
  always_comb begin
    w_steps = CW'(1);
    case (SELECT)
      OP_MUL:         w_steps = CW'(WIDTH);
      OP_SLL, OP_SRA: if (DATA2[SHW-1:0] != '0) w_steps = CW'(DATA2[SHW-1:0]);
      default:        w_steps = CW'(1);
    endcase
  end

  // Value produced by the current step; on the last step this is the result
  always_comb begin
    w_opResult = '0;
    case (r_sel)
      OP_FWD:  w_opResult = r_b;
      OP_ADD:  w_opResult = r_a + r_b;
      OP_AND:  w_opResult = r_a & r_b;
      OP_OR:   w_opResult = r_a | r_b;
      OP_MUL:  w_opResult = w_product;
      OP_SLL:  w_opResult = w_shiftEn ? w_shl : r_a;
      OP_SRA:  w_opResult = w_shiftEn ? w_sra : r_a;
      default: w_opResult = '0;
    endcase
  end

  // Operand latch, step counter and per-step working registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sel   <= '0;
      r_acc   <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_a     <= DATA1;
      r_b     <= DATA2;
      r_sel   <= SELECT;
      r_acc   <= '0;
      r_count <= w_steps;
    end else if (r_state == EXEC) begin
      r_count <= r_count - CW'(1);
      case (r_sel)
        OP_MUL: begin
          r_acc <= w_product;
          r_a   <= w_shl;
          r_b   <= {1'b0, r_b[WIDTH-1:1]};
        end
        OP_SLL, OP_SRA: r_a <= w_opResult;
        default: ;
      endcase
    end
  end

  // Result, zero flag and completion pulse, updated only on the last step
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_result <= '0;
      r_zero   <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_lastStep;
      if (w_lastStep) begin
        r_result <= w_opResult;
        r_zero   <= (w_opResult == '0);
      end
    end
  end

  assign RESULT = r_result;
  assign ZERO   = r_zero;
  assign BUSY   = (r_state == EXEC);
  assign DONE   = r_done;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu: directed and random operations on an
// 8-bit instance compared against an arithmetic reference model, plus a reset
// abort scenario and a 16-bit back-to-back scenario.
module tb_multicycle_alu;

  logic        CLK;
  logic        RESET;
  logic        START;
  logic [7:0]  DATA1;
  logic [7:0]  DATA2;
  logic [2:0]  SELECT;
  logic [7:0]  RESULT;
  logic        ZERO;
  logic        BUSY;
  logic        DONE;

  logic        startW;
  logic [15:0] dataAW;
  logic [15:0] dataBW;
  logic [2:0]  selectW;
  logic [15:0] resultW;
  logic        zeroW;
  logic        busyW;
  logic        doneW;

  int          nVectors;
  int          nMiscompares;
  logic [7:0]  lastResult;
  logic [15:0] expW;
  logic [31:0] prodW;

  multicycle_alu #(.WIDTH(8)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .DATA1(DATA1), .DATA2(DATA2),
    .SELECT(SELECT), .RESULT(RESULT), .ZERO(ZERO), .BUSY(BUSY), .DONE(DONE)
  );

  multicycle_alu #(.WIDTH(16)) dutWide (
    .CLK(CLK), .RESET(RESET), .START(startW), .DATA1(dataAW), .DATA2(dataBW),
    .SELECT(selectW), .RESULT(resultW), .ZERO(zeroW), .BUSY(busyW), .DONE(doneW)
  );

  // Free-running 10 ns clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference result computed from the operation definitions with integer math
  function automatic logic [7:0] refResult(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] sel);
    int ia, ib, n, r;
    ia = int'(a);
    ib = int'(b);
    n  = ib % 8;
    case (sel)
      3'd0: r = ib;
      3'd1: r = ia + ib;
      3'd2: r = ia & ib;
      3'd3: r = ia | ib;
      3'd4: r = ia * ib;
      3'd5: r = ia * (1 << n);
      3'd6: begin
        r = (ia >= 128) ? ia - 256 : ia;
        r = r >>> n;
      end
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  // Reference step count for the 8-bit instance
  function automatic int refSteps(input logic [7:0] b, input logic [2:0] sel);
    int n;
    n = int'(b) % 8;
    if (sel == 3'd4) return 8;
    if (sel == 3'd5 || sel == 3'd6) return (n == 0) ? 1 : n;
    return 1;
  endfunction

  // One comparison: counts it and reports any difference
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nVectors++;
    assert (observed === expected) else begin
      nMiscompares++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      $error("[TB] %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Issue one op (called just after a rising edge) and follow it to completion;
  // optionally fires a stray ADD START while busy, which must be ignored
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [2:0] sel, input bit stray);
    int steps;
    logic [7:0] expR;
    expR  = refResult(a, b, sel);
    steps = refSteps(b, sel);
    DATA1 = a; DATA2 = b; SELECT = sel; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    DATA1 = 8'($urandom); DATA2 = 8'($urandom); SELECT = 3'($urandom);
    checkOutput("accept.busy", BUSY, 1);
    checkOutput("accept.done", DONE, 0);
    for (int i = 1; i <= steps; i++) begin
      if (stray && i == 1 && steps > 1) begin
        START = 1'b1; SELECT = 3'b001;
        DATA1 = 8'($urandom); DATA2 = 8'($urandom);
      end
      @(posedge CLK); #1;
      START = 1'b0;
      if (i < steps) begin
        checkOutput("exec.busy", BUSY, 1);
        checkOutput("exec.done", DONE, 0);
        checkOutput("exec.hold", RESULT, lastResult);
      end else begin
        checkOutput("done.pulse", DONE, 1);
        checkOutput("done.busy", BUSY, 0);
        checkOutput("done.result", RESULT, expR);
        checkOutput("done.zero", ZERO, (expR == 8'h00));
      end
    end
    lastResult = expR;
  endtask

  // Directed and random sequence
  initial begin
    nVectors = 0; nMiscompares = 0; lastResult = 8'h00;
    RESET = 1'b1; START = 1'b0; DATA1 = '0; DATA2 = '0; SELECT = '0;
    startW = 1'b0; dataAW = '0; dataBW = '0; selectW = '0;
    #1;
    checkOutput("rst.result", RESULT, 0);
    checkOutput("rst.zero", ZERO, 1);
    checkOutput("rst.busy", BUSY, 0);
    checkOutput("rst.done", DONE, 0);
    checkOutput("rstW.zero", zeroW, 1);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET = 1'b0;

    applyStimulus(8'h7F, 8'h01, 3'b001, 1'b0);
    applyStimulus(8'd12, 8'd13, 3'b100, 1'b1);
    applyStimulus(8'h90, 8'h03, 3'b110, 1'b0);
    applyStimulus(8'h01, 8'hF8, 3'b101, 1'b0);
    applyStimulus(8'hF0, 8'h0F, 3'b010, 1'b0);
    applyStimulus(8'hA5, 8'h3C, 3'b111, 1'b0);
    applyStimulus(8'h35, 8'h42, 3'b011, 1'b0);

    for (int n = 0; n < 40; n++) begin
      applyStimulus(8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a multiply aborts it asynchronously
    DATA1 = 8'd12; DATA2 = 8'd13; SELECT = 3'b100; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("abort.busyBefore", BUSY, 1);
    #2;
    RESET = 1'b1;
    #1;
    checkOutput("abort.result", RESULT, 0);
    checkOutput("abort.zero", ZERO, 1);
    checkOutput("abort.busy", BUSY, 0);
    checkOutput("abort.done", DONE, 0);
    lastResult = 8'h00;
    DATA1 = 8'h00; DATA2 = 8'h5A; SELECT = 3'b000; START = 1'b1;
    @(posedge CLK); #1;
    checkOutput("abort.startIgnored", BUSY, 0);
    START = 1'b0;
    #2;
    RESET = 1'b0;
    for (int n = 0; n < 2; n++) begin
      @(posedge CLK); #1;
      checkOutput("abort.noDone", DONE, 0);
      checkOutput("abort.idle", BUSY, 0);
    end
    applyStimulus(8'h00, 8'h5A, 3'b000, 1'b0);

    // 16-bit multiply wrapping to zero, then a FORWARD issued in its DONE cycle
    dataAW = 16'h0100; dataBW = 16'h0100; selectW = 3'b100; startW = 1'b1;
    prodW = 32'h0100 * 32'h0100;
    expW = prodW[15:0];
    @(posedge CLK); #1;
    startW = 1'b0;
    repeat (15) @(posedge CLK);
    #1;
    checkOutput("wide.busy", busyW, 1);
    @(posedge CLK); #1;
    checkOutput("wide.done", doneW, 1);
    checkOutput("wide.result", resultW, expW);
    checkOutput("wide.zero", zeroW, 1);
    dataBW = 16'hBEEF; selectW = 3'b000; startW = 1'b1;
    @(posedge CLK); #1;
    startW = 1'b0;
    checkOutput("wide.b2bBusy", busyW, 1);
    checkOutput("wide.b2bDoneLow", doneW, 0);
    @(posedge CLK); #1;
    checkOutput("wide.b2bDone", doneW, 1);
    checkOutput("wide.b2bResult", resultW, 16'hBEEF);
    checkOutput("wide.b2bZero", zeroW, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
